// File: rtl/rggen_apb_master_if.sv
// APB4 bundle shared by the rggen APB initiator and its responders.
interface rggen_apb_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      psel;
    logic                      penable;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [2:0]                pprot;
    logic                      pwrite;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/rggen_apb_master.sv
// APB4 initiator: one valid/ready command in, one APB transfer, one valid/ready response out.
// Optional ACCESS-phase timeout is compiled in with RGGEN_APB_MASTER_TIMEOUT_EN.
module rggen_apb_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]   i_cmd_address,
    input  logic [DATA_WIDTH-1:0]      i_cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]    i_cmd_strobe,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [DATA_WIDTH-1:0]      o_rsp_read_data,
    output logic [1:0]                 o_rsp_status,
    rggen_apb_if.master                apb_if
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);

    localparam logic [1:0] STATUS_OKAY    = 2'b00;
    localparam logic [1:0] STATUS_SLVERR  = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    if (!(DATA_WIDTH inside {8, 16, 32})) begin : g_bad_data_width
        $error("rggen_apb_master: DATA_WIDTH must be 8, 16 or 32");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rggen_apb_master: TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESPONSE
    } state_e;

    state_e                     state_q, state_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
    logic                       pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]      pstrb_q, pstrb_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_status_q, rsp_status_d;

`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        timeout_hit;

    assign timeout_hit = (timeout_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
        timeout_cnt_d = timeout_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = i_cmd_address & ADDR_MASK;
                    pwrite_d  = i_cmd_write;
                    pwdata_d  = i_cmd_write ? i_cmd_write_data : '0;
                    pstrb_d   = i_cmd_write ? i_cmd_strobe : '0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
                timeout_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                // A completing pready takes priority over an expiring timeout.
                if (apb_if.pready) begin
                    state_d      = ST_RESPONSE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = apb_if.pslverr ? STATUS_SLVERR : STATUS_OKAY;
                    rsp_data_d   = (!pwrite_q && !apb_if.pslverr) ? apb_if.prdata : '0;
                end else begin
`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
                    if (timeout_hit) begin
                        state_d      = ST_RESPONSE;
                        psel_d       = 1'b0;
                        penable_d    = 1'b0;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = STATUS_TIMEOUT;
                        rsp_data_d   = '0;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
`endif
                end
            end
            ST_RESPONSE: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= STATUS_OKAY;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`endif

    assign o_cmd_ready     = cmd_ready_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_read_data = rsp_data_q;
    assign o_rsp_status    = rsp_status_q;

    assign apb_if.psel    = psel_q;
    assign apb_if.penable = penable_q;
    assign apb_if.paddr   = paddr_q;
    assign apb_if.pprot   = 3'b000;
    assign apb_if.pwrite  = pwrite_q;
    assign apb_if.pwdata  = pwdata_q;
    assign apb_if.pstrb   = pstrb_q;

endmodule
